// File: rtl/reg_bank_ula.sv
// Four-entry register bank feeding a two-stage ALU (ADD/SUB/AND/MUL).
// Stage 1 latches the operands, and stage 2 registers a 2*DW-bit result with a one-cycle valid pulse.
module reg_bank_ula #(
    parameter int DW = 16
) (
    input  logic            clk_ula,
    input  logic            rst,
    input  logic            valid_reg,
    input  logic [DW-1:0]   data_in,
    input  logic [1:0]      addr,
    input  logic            valid_ula,
    input  logic [DW-1:0]   A,
    input  logic [1:0]      reg_sel,
    input  logic [1:0]      instru,
    output logic [2*DW-1:0] data_out,
    output logic            valid_out
);
    localparam int STAGES = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] r;
        op_e           op;
    } req_t;

    logic [3:0][DW-1:0]  regs;
    req_t                s1;
    logic [STAGES:1]     vld_pipe;
    logic [DW:0]         sum, diff;
    logic [2*DW-1:0]     prod, res;

    always_ff @(posedge clk_ula or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else if (valid_reg) begin
            regs[addr] <= data_in;
        end
    end

    // Operand read happens at the same edge as any write, so the operation
    // naturally sees the pre-write register value.
    always_ff @(posedge clk_ula or negedge rst) begin
        if (!rst) begin
            s1       <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], valid_ula};
            if (valid_ula) begin
                s1.a  <= A;
                s1.r  <= regs[reg_sel];
                s1.op <= op_e'(instru);
            end
        end
    end

    always_comb begin
        sum  = {1'b0, s1.a} + {1'b0, s1.r};
        diff = {1'b0, s1.a} - {1'b0, s1.r};
        prod = {{DW{1'b0}}, s1.a} * {{DW{1'b0}}, s1.r};
        res  = '0;
        case (s1.op)
            OP_ADD: res = {{(DW-1){1'b0}}, sum};
            // The DW+1-bit difference carries the borrow as its sign bit.
            OP_SUB: res = {{(DW-1){diff[DW]}}, diff};
            OP_AND: res = {{DW{1'b0}}, s1.a & s1.r};
            OP_MUL: res = prod;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk_ula or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
        end else if (vld_pipe[1]) begin
            data_out <= res;
        end
    end

    assign valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_reg_bank_ula.sv
// Directed testbench for reg_bank_ula: register writes, ALU ops, hazards, pipelining and reset flush.
module tb_reg_bank_ula;
    localparam int DW = 16;

    logic            clk_ula;
    logic            rst;
    logic            valid_reg;
    logic [DW-1:0]   data_in;
    logic [1:0]      addr;
    logic            valid_ula;
    logic [DW-1:0]   A;
    logic [1:0]      reg_sel;
    logic [1:0]      instru;
    logic [2*DW-1:0] data_out;
    logic            valid_out;

    int tests = 0;
    int fails = 0;

    reg_bank_ula #(.DW(DW)) dut (
        .clk_ula  (clk_ula),
        .rst      (rst),
        .valid_reg(valid_reg),
        .data_in  (data_in),
        .addr     (addr),
        .valid_ula(valid_ula),
        .A        (A),
        .reg_sel  (reg_sel),
        .instru   (instru),
        .data_out (data_out),
        .valid_out(valid_out)
    );

    initial begin
        clk_ula = 1'b0;
        forever #5 clk_ula = ~clk_ula;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_ula);
        #1;
    endtask

    task automatic drive(input logic vr, input logic [1:0] ad, input logic [DW-1:0] d,
                         input logic vu, input logic [DW-1:0] a, input logic [1:0] sel,
                         input logic [1:0] op);
        valid_reg = vr; addr = ad; data_in = d;
        valid_ula = vu; A = a; reg_sel = sel; instru = op;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, '0, 1'b0, '0, 2'd0, 2'd0);
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #3;
        tests++;
        if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        tests++;
        if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 00000000", data_out); end
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_mul();
        drive(1'b1, 2'd2, 16'h0003, 1'b0, '0, 2'd0, 2'd0);
        tick();
        drive(1'b0, 2'd0, '0, 1'b1, 16'h0005, 2'd2, 2'b11);
        tick();
        tests++;
        if (valid_out !== 1'b0) begin fails++; $display("FAIL mul_early_valid: got %b want 0", valid_out); end
        idle();
        tick();
        tests++;
        if (valid_out !== 1'b1 || data_out !== 32'h0000000F) begin
            fails++; $display("FAIL mul_result: got v=%b d=%h want v=1 d=0000000f", valid_out, data_out);
        end
        tick();
        tests++;
        if (valid_out !== 1'b0 || data_out !== 32'h0000000F) begin
            fails++; $display("FAIL mul_hold: got v=%b d=%h want v=0 d=0000000f", valid_out, data_out);
        end
    endtask

    task automatic test_add_sub();
        drive(1'b1, 2'd1, 16'hFFFF, 1'b0, '0, 2'd0, 2'd0);
        tick();
        drive(1'b0, 2'd0, '0, 1'b1, 16'h0001, 2'd1, 2'b00);
        tick();
        idle();
        tick();
        tests++;
        if (valid_out !== 1'b1 || data_out !== 32'h00010000) begin
            fails++; $display("FAIL add_carry: got v=%b d=%h want v=1 d=00010000", valid_out, data_out);
        end
        drive(1'b1, 2'd1, 16'h0002, 1'b0, '0, 2'd0, 2'd0);
        tick();
        drive(1'b0, 2'd0, '0, 1'b1, 16'h0001, 2'd1, 2'b01);
        tick();
        idle();
        tick();
        tests++;
        if (valid_out !== 1'b1 || data_out !== 32'hFFFFFFFF) begin
            fails++; $display("FAIL sub_neg: got v=%b d=%h want v=1 d=ffffffff", valid_out, data_out);
        end
    endtask

    task automatic test_hazard();
        drive(1'b1, 2'd0, 16'h00AA, 1'b0, '0, 2'd0, 2'd0);
        tick();
        drive(1'b1, 2'd0, 16'h0F0F, 1'b1, 16'hFFFF, 2'd0, 2'b10);
        tick();
        drive(1'b0, 2'd0, '0, 1'b1, 16'hFFFF, 2'd0, 2'b10);
        tick();
        tests++;
        if (valid_out !== 1'b1 || data_out !== 32'h000000AA) begin
            fails++; $display("FAIL hazard_prewrite: got v=%b d=%h want v=1 d=000000aa", valid_out, data_out);
        end
        idle();
        tick();
        tests++;
        if (valid_out !== 1'b1 || data_out !== 32'h00000F0F) begin
            fails++; $display("FAIL hazard_postwrite: got v=%b d=%h want v=1 d=00000f0f", valid_out, data_out);
        end
        tick();
        tests++;
        if (valid_out !== 1'b0) begin fails++; $display("FAIL hazard_single_pulse: got %b want 0", valid_out); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0]   rv   [4] = '{16'h0010, 16'h0003, 16'h00F0, 16'h0007};
        logic [DW-1:0]   av   [4] = '{16'h0005, 16'h0001, 16'h003C, 16'h1234};
        logic [1:0]      opv  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [2*DW-1:0] expv [4] = '{32'h00000015, 32'hFFFFFFFE, 32'h00000030, 32'h00007F6C};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), rv[i], 1'b0, '0, 2'd0, 2'd0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b0, 2'd0, '0, 1'b1, av[i], 2'(i), opv[i]);
            else       idle();
            tick();
            if (i >= 1) begin
                tests++;
                if (valid_out !== 1'b1 || data_out !== expv[i-1]) begin
                    fails++;
                    $display("FAIL b2b_op%0d: got v=%b d=%h want v=1 d=%h", i-1, valid_out, data_out, expv[i-1]);
                end
            end
        end
        tick();
        tests++;
        if (valid_out !== 1'b0) begin fails++; $display("FAIL b2b_end: got %b want 0", valid_out); end
    endtask

    task automatic test_boundaries();
        drive(1'b1, 2'd3, 16'hFFFF, 1'b0, '0, 2'd0, 2'd0);
        tick();
        drive(1'b0, 2'd0, '0, 1'b1, 16'hFFFF, 2'd3, 2'b00);
        tick();
        drive(1'b0, 2'd0, '0, 1'b1, 16'hFFFF, 2'd3, 2'b11);
        tick();
        tests++;
        if (valid_out !== 1'b1 || data_out !== 32'h0001FFFE) begin
            fails++; $display("FAIL add_max: got v=%b d=%h want v=1 d=0001fffe", valid_out, data_out);
        end
        idle();
        tick();
        tests++;
        if (valid_out !== 1'b1 || data_out !== 32'hFFFE0001) begin
            fails++; $display("FAIL mul_max: got v=%b d=%h want v=1 d=fffe0001", valid_out, data_out);
        end
    endtask

    task automatic test_reset_flush();
        drive(1'b0, 2'd0, '0, 1'b1, 16'h0001, 2'd0, 2'b00);
        tick();
        idle();
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (valid_out !== 1'b0 || data_out !== 32'h0) begin
            fails++; $display("FAIL flush_async: got v=%b d=%h want v=0 d=00000000", valid_out, data_out);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (valid_out !== 1'b0 || data_out !== 32'h0) begin
                fails++; $display("FAIL flush_no_pulse%0d: got v=%b d=%h want v=0 d=00000000", i, valid_out, data_out);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b0, 2'd0, '0, 1'b1, 16'h0001, 2'(i), 2'b00);
            else       idle();
            tick();
            if (i >= 1) begin
                tests++;
                if (valid_out !== 1'b1 || data_out !== 32'h00000001) begin
                    fails++; $display("FAIL flush_reg%0d: got v=%b d=%h want v=1 d=00000001", i-1, valid_out, data_out);
                end
            end
        end
    endtask

    task automatic test_idle();
        int bad = 0;
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 1'b0, 16'($urandom),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            tick();
            if (valid_out !== 1'b0 || data_out !== 32'h00000001) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL idle_hold: got %0d bad cycles want 0", bad); end
        drive(1'b0, 2'd0, '0, 1'b1, 16'h0000, 2'd0, 2'b00);
        tick();
        idle();
        tick();
        tests++;
        if (valid_out !== 1'b1 || data_out !== 32'h0) begin
            fails++; $display("FAIL idle_no_write: got v=%b d=%h want v=1 d=00000000", valid_out, data_out);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        test_reset();
        test_mul();
        test_add_sub();
        test_hazard();
        test_back_to_back();
        test_boundaries();
        test_reset_flush();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
